// File: rtl/trigger_multistage_pkg.sv
// Shared types and config-word layout for the multi-stage capture trigger.
package trigger_pkg;

  typedef enum logic [1:0] {
    CFG_MASK   = 2'd0,
    CFG_VALUE  = 2'd1,
    CFG_CONFIG = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_sel_e;

  localparam int CFG_DELAY_LSB  = 0;
  localparam int CFG_LEVEL_LSB  = 16;
  localparam int CFG_START_BIT  = 27;
  localparam int CFG_EDGE_BIT   = 28;
  localparam int CFG_ENABLE_BIT = 31;

  typedef struct packed {
    logic        enable;
    logic        edge_mode;
    logic        start;
    logic [1:0]  level;
    logic [15:0] delay;
  } stage_cfg_t;

endpackage

// File: rtl/trigger_multistage_if.sv
// Config write bus and sample stream feeding the multi-stage trigger.
interface trigger_multistage_if #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4
);
  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                    cfg_wr;
  logic [STAGE_W-1:0]      cfg_stage;
  logic [1:0]              cfg_sel;
  logic [31:0]             cfg_data;
  logic                    valid;
  logic [SAMPLE_WIDTH-1:0] data_in;

  modport master (output cfg_wr, cfg_stage, cfg_sel, cfg_data, valid, data_in);
  modport slave  (input  cfg_wr, cfg_stage, cfg_sel, cfg_data, valid, data_in);
endinterface

// File: rtl/trigger_multistage_stage.sv
// One trigger stage: mask/value/config registers, match/edge detect and a
// delay counter that reports a fire on the sample where the delay completes.
module trigger_stage
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DELAY_WIDTH  = 16,
  parameter bit IS_FIRST     = 1'b0
) (
  input  logic                    system_clock,
  input  logic                    ext_reset_n,
  input  logic                    clear,
  input  logic                    arm,
  input  logic                    armed,
  input  logic                    cancel,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic [1:0]              level,
  input  logic                    wr_mask,
  input  logic                    wr_value,
  input  logic                    wr_cfg,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  stage_cfg_t              wr_cfg_word,
  output logic                    fire,
  output logic                    start
);

  // Stage 0 defaults to enable|start so an unconfigured trigger fires at once.
  localparam stage_cfg_t RESET_CFG = '{
    enable: IS_FIRST, edge_mode: 1'b0, start: IS_FIRST, level: 2'd0, delay: 16'd0
  };

  logic [SAMPLE_WIDTH-1:0] mask, value;
  stage_cfg_t              cfg;
  logic                    pending, prev_cond;
  logic [DELAY_WIDTH-1:0]  count;

  logic                    data_cond, match, eval;
  logic [DELAY_WIDTH-1:0]  count_next, delay;

  assign delay      = cfg.delay[DELAY_WIDTH-1:0];
  assign data_cond  = ((data_in ^ value) & mask) == '0;
  assign match      = cfg.enable && (cfg.level == level) && data_cond &&
                      (!cfg.edge_mode || !prev_cond);
  assign eval       = valid && armed;
  assign count_next = count + DELAY_WIDTH'(1);
  assign fire       = eval && (pending ? (count_next == delay)
                                       : (match && (delay == '0)));
  assign start      = cfg.start;

  // NOTE: config is a handful of flops with defined reset values, not a RAM,
  // so it is reset like any other state.
  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      mask  <= '0;
      value <= '0;
      cfg   <= RESET_CFG;
    end else begin
      if (wr_mask)  mask  <= wr_data;
      if (wr_value) value <= wr_data;
      if (wr_cfg)   cfg   <= wr_cfg_word;
    end
  end

  // Edge history tracks the data condition only, independent of level.
  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      pending   <= 1'b0;
      count     <= '0;
      prev_cond <= 1'b0;
    end else if (clear || arm) begin
      pending   <= 1'b0;
      count     <= '0;
      prev_cond <= 1'b0;
    end else if (eval) begin
      prev_cond <= data_cond;
      if (cancel || fire) begin
        pending <= 1'b0;
      end else if (pending) begin
        count <= count_next;
      end else if (match) begin
        pending <= 1'b1;
        count   <= '0;
      end
    end
  end

endmodule

// File: rtl/trigger_multistage.sv
// Multi-stage capture trigger: config decode, fire arbitration, level, run and armed.
module trigger_multistage
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int DELAY_WIDTH  = 16
) (
  input  logic                  system_clock,
  input  logic                  ext_reset_n,
  input  logic                  clear,
  input  logic                  arm,
  trigger_multistage_if.slave   bus,
  output logic                  run,
  output logic                  armed,
  output logic [1:0]            level,
  output logic [NUM_STAGES-1:0] stage_hit
);

  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  stage_cfg_t            cfg_word;
  logic [NUM_STAGES-1:0] fire_vec, start_vec;
  logic                  any_fire, any_start, cancel;
  logic                  unused_cfg_bits;

  // NOTE: every field gets a default first so no latch is inferred.
  always_comb begin
    cfg_word           = '0;
    cfg_word.enable    = bus.cfg_data[CFG_ENABLE_BIT];
    cfg_word.edge_mode = bus.cfg_data[CFG_EDGE_BIT];
    cfg_word.start     = bus.cfg_data[CFG_START_BIT];
    cfg_word.level     = bus.cfg_data[CFG_LEVEL_LSB +: 2];
    cfg_word.delay     = 16'(bus.cfg_data[CFG_DELAY_LSB +: DELAY_WIDTH]);
  end

  assign unused_cfg_bits = ^{bus.cfg_data[26:18], bus.cfg_data[30:29]};

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic stage_sel;
    assign stage_sel = bus.cfg_wr && !armed && (bus.cfg_stage == STAGE_W'(i));

    trigger_stage #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .DELAY_WIDTH (DELAY_WIDTH),
      .IS_FIRST    (i == 0)
    ) u_stage (
      .system_clock(system_clock),
      .ext_reset_n (ext_reset_n),
      .clear       (clear),
      .arm         (arm),
      .armed       (armed),
      .cancel      (cancel),
      .valid       (bus.valid),
      .data_in     (bus.data_in),
      .level       (level),
      .wr_mask     (stage_sel && (bus.cfg_sel == CFG_MASK)),
      .wr_value    (stage_sel && (bus.cfg_sel == CFG_VALUE)),
      .wr_cfg      (stage_sel && (bus.cfg_sel == CFG_CONFIG)),
      .wr_data     (bus.cfg_data[SAMPLE_WIDTH-1:0]),
      .wr_cfg_word (cfg_word),
      .fire        (fire_vec[i]),
      .start       (start_vec[i])
    );
  end

  // A start fire takes precedence; otherwise any fire advances one level.
  assign any_fire  = |fire_vec;
  assign any_start = |(fire_vec & start_vec);
  assign cancel    = any_fire && !any_start;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      run       <= 1'b0;
      armed     <= 1'b0;
      level     <= 2'd0;
      stage_hit <= '0;
    end else if (clear) begin
      run       <= 1'b0;
      armed     <= 1'b0;
      level     <= 2'd0;
      stage_hit <= '0;
    end else if (arm) begin
      run       <= 1'b0;
      armed     <= 1'b1;
      level     <= 2'd0;
      stage_hit <= '0;
    end else begin
      stage_hit <= fire_vec;
      if (any_start) begin
        run   <= 1'b1;
        armed <= 1'b0;
      end else if (any_fire && (level != 2'd3)) begin
        level <= level + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_trigger_multistage.sv
// Scoreboard bench for trigger_multistage: expected outputs queued per cycle of stimulus.
module tb_trigger_multistage;

  typedef struct packed {
    logic       run;
    logic       armed;
    logic [1:0] level;
    logic [3:0] hit;
  } obs_t;

  logic       system_clock;
  logic       ext_reset_n;
  logic       clear;
  logic       arm;
  logic       run;
  logic       armed;
  logic [1:0] level;
  logic [3:0] stage_hit;

  int vectors     = 0;
  int miscompares = 0;

  obs_t exp_q[$];
  obs_t obs_q[$];

  trigger_multistage_if #(.SAMPLE_WIDTH(8), .NUM_STAGES(4)) bus ();

  trigger_multistage #(
    .SAMPLE_WIDTH(8),
    .NUM_STAGES  (4),
    .DELAY_WIDTH (16)
  ) dut (
    .system_clock(system_clock),
    .ext_reset_n (ext_reset_n),
    .clear       (clear),
    .arm         (arm),
    .bus         (bus.slave),
    .run         (run),
    .armed       (armed),
    .level       (level),
    .stage_hit   (stage_hit)
  );

  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  function automatic obs_t mk(input logic r, input logic a, input logic [1:0] l,
                              input logic [3:0] h);
    return '{run: r, armed: a, level: l, hit: h};
  endfunction

  function automatic obs_t observe();
    return '{run: run, armed: armed, level: level, hit: stage_hit};
  endfunction

  // One cycle of stimulus; expectation queued now, observation after the edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic a,
                      input logic c, input obs_t e);
    bus.valid   = v;
    bus.data_in = d;
    arm         = a;
    clear       = c;
    bus.cfg_wr  = 1'b0;
    exp_q.push_back(e);
    @(posedge system_clock);
    #1;
    obs_q.push_back(observe());
    bus.valid = 1'b0;
    arm       = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic wcfg(input int stage, input logic [1:0] sel, input logic [31:0] data);
    bus.cfg_wr    = 1'b1;
    bus.cfg_stage = 2'(stage);
    bus.cfg_sel   = sel;
    bus.cfg_data  = data;
    @(posedge system_clock);
    #1;
    bus.cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge system_clock);
    #1;
    ext_reset_n = 1'b0;
    clear       = 1'b0;
    arm         = 1'b0;
    bus.valid   = 1'b0;
    bus.cfg_wr  = 1'b0;
    @(posedge system_clock);
    #1;
    ext_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    do_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b0, mk(0, 0, 2'd0, 4'b0000));
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    do_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b0, mk(0, 0, 2'd0, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(0, 0, 2'd0, 4'b0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_default(input string name);
    obs_t e, o;
    do_reset();
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(1, 0, 2'd0, 4'b0001));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(1, 0, 2'd0, 4'b0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 name, o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_value_match();
    obs_t e, o;
    do_reset();
    wcfg(0, 2'd0, 32'h0000_00FF);
    wcfg(0, 2'd1, 32'h0000_00A5);
    wcfg(0, 2'd2, 32'h8800_0000);
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h5A, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b0, 8'hA5, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'hA5, 1'b0, 1'b0, mk(1, 0, 2'd0, 4'b0001));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL value_match: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_delay();
    obs_t e, o;
    do_reset();
    wcfg(0, 2'd0, 32'h0000_000F);
    wcfg(0, 2'd1, 32'h0000_0003);
    wcfg(0, 2'd2, 32'h8000_0000);
    wcfg(1, 2'd0, 32'h0000_00FF);
    wcfg(1, 2'd1, 32'h0000_00C0);
    wcfg(1, 2'd2, 32'h8801_0003);
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h13, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0001));
    tick(1'b1, 8'hC0, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b0, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b0, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b0, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(1, 0, 2'd1, 4'b0010));
    tick(1'b1, 8'h13, 1'b0, 1'b0, mk(1, 0, 2'd1, 4'b0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL delay: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_edge();
    obs_t e, o;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      wcfg(s, 2'd0, 32'h0000_0001);
      wcfg(s, 2'd1, 32'h0000_0001);
    end
    wcfg(0, 2'd2, 32'h9000_0000);
    wcfg(1, 2'd2, 32'h9001_0000);
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h01, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0001));
    tick(1'b1, 8'h01, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b1, 8'h00, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0000));
    tick(1'b1, 8'h01, 1'b0, 1'b0, mk(0, 1, 2'd2, 4'b0010));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL edge: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, o;
    do_reset();
    for (int s = 0; s < 4; s++) wcfg(s, 2'd2, 32'h8000_0000 | (32'(s) << 16));
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h37, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0001));
    tick(1'b1, 8'h37, 1'b0, 1'b0, mk(0, 1, 2'd2, 4'b0010));
    tick(1'b1, 8'h37, 1'b0, 1'b0, mk(0, 1, 2'd3, 4'b0100));
    tick(1'b1, 8'h37, 1'b0, 1'b0, mk(0, 1, 2'd3, 4'b1000));
    tick(1'b1, 8'h37, 1'b0, 1'b0, mk(0, 1, 2'd3, 4'b1000));
    tick(1'b1, 8'h37, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL saturate: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_lock_clear_rearm();
    obs_t e, o;
    do_reset();
    wcfg(0, 2'd2, 32'h8800_0002);
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    wcfg(0, 2'd2, 32'h8800_0000);
    tick(1'b1, 8'h11, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h22, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h33, 1'b1, 1'b1, mk(0, 0, 2'd0, 4'b0000));
    tick(1'b1, 8'h44, 1'b0, 1'b0, mk(0, 0, 2'd0, 4'b0000));
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h55, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h66, 1'b0, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h77, 1'b0, 1'b0, mk(1, 0, 2'd0, 4'b0001));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL lock_clear_rearm: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    do_reset();
    wcfg(0, 2'd2, 32'h8000_0000);
    wcfg(1, 2'd2, 32'h8000_0000);
    wcfg(2, 2'd2, 32'h8001_0000);
    wcfg(3, 2'd2, 32'h8801_0000);
    tick(1'b0, 8'h00, 1'b1, 1'b0, mk(0, 1, 2'd0, 4'b0000));
    tick(1'b1, 8'h9C, 1'b0, 1'b0, mk(0, 1, 2'd1, 4'b0011));
    tick(1'b1, 8'h9C, 1'b0, 1'b0, mk(1, 0, 2'd1, 4'b1100));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back: got run=%b armed=%b level=%0d hit=%b, want run=%b armed=%b level=%0d hit=%b",
                 o.run, o.armed, o.level, o.hit, e.run, e.armed, e.level, e.hit);
      end
    end
  endtask

  initial begin
    ext_reset_n   = 1'b0;
    clear         = 1'b0;
    arm           = 1'b0;
    bus.cfg_wr    = 1'b0;
    bus.cfg_stage = '0;
    bus.cfg_sel   = 2'd0;
    bus.cfg_data  = '0;
    bus.valid     = 1'b0;
    bus.data_in   = '0;

    test_reset();
    test_default("default_cfg");
    test_value_match();
    test_delay();
    test_edge();
    test_saturate();
    test_lock_clear_rearm();
    test_back_to_back();
    test_default("default_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
